// File: rtl/ifetch_ahb_master.sv
// Instruction-fetch master on AHB-Lite: issues one single-beat read at a time and
// buffers returned words with their PCs in a small FIFO for the decode stage.
module ifetch_ahb_master #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        HCLK,
   input  logic        HRESET,
   output logic [63:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_addr,
   output logic        fetch_valid,
   input  logic        fetch_ready,
   output logic [31:0] fetch_instr,
   output logic [63:0] fetch_pc
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {ST_ADDR, ST_DATA, ST_DROP} state_t;

   state_t             r_state;
   logic [63:0]        r_pc;
   logic [31:0]        r_mem_instr [FIFO_DEPTH];
   logic [63:0]        r_mem_pc    [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [CNT_W-1:0]   r_count;

   logic               w_full;
   logic               w_valid;
   logic               w_issue;
   logic               w_push;
   logic               w_pop;
   logic [63:0]        w_redir_pc;
   logic               w_unused;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Issue decisions use the registered count, so a same-cycle pop never frees a slot early.
   assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_valid    = (r_count != '0);
   assign w_issue    = (r_state == ST_ADDR) && !w_full && !redirect_valid && !HRESET;
   assign w_push     = (r_state == ST_DATA) && HREADY && !redirect_valid;
   assign w_pop      = w_valid && fetch_ready && !redirect_valid;
   assign w_redir_pc = {redirect_addr[63:2], 2'b00};
   assign w_unused   = ^redirect_addr[1:0];

   assign HTRANS      = w_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR       = r_pc;
   assign HWRITE      = 1'b0;
   assign HWDATA      = 32'h0;
   assign fetch_valid = w_valid;
   assign fetch_instr = w_valid ? r_mem_instr[r_rptr] : 32'h0;
   assign fetch_pc    = w_valid ? r_mem_pc[r_rptr]    : 64'h0;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state <= ST_ADDR;
         r_pc    <= RESET_PC;
      end else begin
         case (r_state)
            ST_ADDR: begin
               if (redirect_valid) begin
                  r_pc <= w_redir_pc;
               end else if (w_issue) begin
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (redirect_valid) begin
                  r_pc    <= w_redir_pc;
                  r_state <= HREADY ? ST_ADDR : ST_DROP;
               end else if (HREADY) begin
                  r_pc    <= r_pc + 64'd4;
                  r_state <= ST_ADDR;
               end
            end
            ST_DROP: begin
               // Wait out the abandoned data phase; only the newest redirect target survives.
               if (redirect_valid) begin
                  r_pc <= w_redir_pc;
               end
               if (HREADY) begin
                  r_state <= ST_ADDR;
               end
            end
            default: r_state <= ST_ADDR;
         endcase
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET || redirect_valid) begin
         r_count <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= ptr_inc(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= ptr_inc(r_rptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge HCLK) begin
      if (w_push && !HRESET) begin
         r_mem_instr[r_wptr] <= HRDATA;
         r_mem_pc[r_wptr]    <= r_pc;
      end
   end

endmodule
